// File: rtl/im_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the fetch/IM side:
// loader FSM states, instruction RAM base address and depth.
package im_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    WRITE,
    DONE,
    ERR
  } im_state_e;

  localparam logic [31:0] IM_BASE_ADDR = 32'h0000_3000;
  localparam int          IM_DEPTH     = 4096;

  // Byte address of instruction word number idx.
  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/im_loader_word_packer.sv
// Byte-index counter plus shift register that assembles big-endian 32-bit
// words; next_word_o is the word that the current byte would complete.
module im_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] next_word_o,
  output logic        full_o
);

  logic [1:0]  idx_q;
  logic [23:0] word_q;

  // Only three earlier bytes need storing; the fourth comes straight from byte_i.
  assign next_word_o = {word_q, byte_i};
  assign full_o      = (idx_q == 2'd3);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q  <= 2'd0;
      word_q <= 24'd0;
    end else if (clear_i) begin
      idx_q  <= 2'd0;
      word_q <= 24'd0;
    end else if (shift_i) begin
      idx_q  <= idx_q + 2'd1;
      word_q <= next_word_o[23:0];
    end
  end

endmodule

// File: rtl/im_loader.sv
// Boot loader: takes a length-prefixed byte stream over valid/ready and
// writes big-endian 32-bit words into instruction RAM from BASE_ADDR upward.
module im_loader
  import im_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = IM_BASE_ADDR,
  parameter int          DEPTH     = IM_DEPTH,
  parameter int          CNT_W     = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             im_we,
  output logic [31:0]      im_addr,
  output logic [31:0]      im_wdata,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] word_count,
  output im_state_e        dbg_state
);

  // Handshake: a byte moves on a rising edge where in_valid && in_ready.
  // in_ready depends on the registered state only, never on in_valid.

  localparam logic [31:0] DEPTH_U = DEPTH;

  im_state_e        state_q, state_d;
  logic [15:0]      len_q, len_d;
  logic [CNT_W-1:0] wc_q, wc_d;
  logic [CNT_W-1:0] wc_inc;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [15:0]      hdr_len;
  logic             accept;
  logic             pk_clear;
  logic             pk_shift;
  logic             pk_full;
  logic [31:0]      pk_word;

  im_word_packer u_packer (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (pk_clear),
    .shift_i     (pk_shift),
    .byte_i      (in_data),
    .next_word_o (pk_word),
    .full_o      (pk_full)
  );

  assign in_ready   = (state_q inside {LEN_HI, LEN_LO, DATA});
  assign accept     = in_valid && in_ready;
  assign hdr_len    = {len_q[15:8], in_data};
  assign wc_inc     = wc_q + CNT_W'(1);
  assign im_we      = (state_q == WRITE);
  assign im_addr    = addr_q;
  assign im_wdata   = wdata_q;
  assign busy       = (state_q inside {LEN_HI, LEN_LO, DATA, WRITE});
  assign done       = (state_q == DONE);
  assign err        = (state_q == ERR);
  assign word_count = wc_q;
  assign dbg_state  = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q   <= 16'd0;
      wc_q    <= '0;
      addr_q  <= BASE_ADDR;
      wdata_q <= 32'd0;
    end else begin
      len_q   <= len_d;
      wc_q    <= wc_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    wc_d     = wc_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    pk_clear = 1'b0;
    pk_shift = 1'b0;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d  = LEN_HI;
          len_d    = 16'd0;
          wc_d     = '0;
          pk_clear = 1'b1;
        end
      end
      LEN_HI: begin
        if (accept) begin
          len_d   = {in_data, len_q[7:0]};
          state_d = LEN_LO;
        end
      end
      LEN_LO: begin
        if (accept) begin
          len_d    = hdr_len;
          wc_d     = '0;
          pk_clear = 1'b1;
          // Oversized headers are rejected before any data byte is taken.
          if (hdr_len == 16'd0) begin
            state_d = DONE;
          end else if ({16'd0, hdr_len} > DEPTH_U) begin
            state_d = ERR;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          pk_shift = 1'b1;
          if (pk_full) begin
            state_d = WRITE;
            wdata_d = pk_word;
            addr_d  = word_addr(BASE_ADDR, 32'(wc_q));
          end
        end
      end
      WRITE: begin
        wc_d    = wc_inc;
        state_d = (32'(wc_inc) == 32'(len_q)) ? DONE : DATA;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: table-driven sessions, hand-written
// corner sequences and randomized sessions scored against a reference model.
module tb_im_loader;
  import im_loader_pkg::*;

  localparam logic [31:0] BASE  = 32'h0000_3000;
  localparam int          DEPTH = 4096;
  localparam int          CNT_W = 13;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             im_we;
  logic [31:0]      im_addr;
  logic [31:0]      im_wdata;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] word_count;
  im_state_e        dbg_state;

  int errors = 0;
  int checks = 0;

  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];
  logic [31:0] data_q[$];

  typedef struct {
    int          n;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    bit          gaps;
    bit          start_mid;
    bit          exp_done;
    bit          exp_err;
    int          exp_wc;
  } vec_t;

  vec_t vecs[6];

  im_loader #(
    .BASE_ADDR (BASE),
    .DEPTH     (DEPTH),
    .CNT_W     (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .im_we      (im_we),
    .im_addr    (im_addr),
    .im_wdata   (im_wdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .word_count (word_count),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------- write monitor ----------------
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      obs_q.push_back({im_addr, im_wdata});
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL ready_in_write: in_ready=%0b expected 0 at addr %08h", in_ready, im_addr);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit rdy;
    bit ok;
    if (gaps) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      repeat ($urandom_range(0, 2)) tick();
    end
    in_valid = 1'b1;
    in_data  = b;
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      ok = rdy;
    end
    if (!ok) begin
      errors++;
      $display("FAIL byte_accept: byte %02h not accepted within 50 cycles", b);
    end
    in_valid = 1'b0;
  endtask

  // ---------------- reference model ----------------
  // Expected write list from the stream rules: headers 1..DEPTH write word i
  // at BASE + 4*i; a zero or oversized header writes nothing.
  task automatic model_writes(input int n);
    exp_q.delete();
    if (n >= 1 && n <= DEPTH) begin
      for (int i = 0; i < n; i++) begin
        exp_q.push_back({BASE + 32'(i) * 32'd4, data_q[i]});
      end
    end
  endtask

  task automatic run_session(input int n, input bit gaps, input bit start_mid,
                             input bit exp_done, input bit exp_err, input int exp_wc);
    logic [15:0] n16;
    logic [31:0] w;
    bit          fin;
    n16 = n[15:0];
    obs_q.delete();
    model_writes(n);
    pulse_start();
    check("busy_after_start", 64'(busy), 64'd1);
    send_byte(n16[15:8], gaps);
    send_byte(n16[7:0], gaps);
    if (n == 0 || n > DEPTH) begin
      check("hdr_done_now", 64'(done), 64'(exp_done));
      check("hdr_err_now", 64'(err), 64'(exp_err));
      check("hdr_ready_low", 64'(in_ready), 64'd0);
    end else begin
      for (int i = 0; i < n; i++) begin
        w = data_q[i];
        for (int b = 0; b < 4; b++) begin
          if (start_mid && i == 1 && b == 1) start = 1'b1;
          send_byte(w[31-8*b -: 8], gaps);
          start = 1'b0;
        end
      end
    end
    fin = 1'b0;
    for (int c = 0; c < 20 && !fin; c++) begin
      @(negedge clk);
      fin = done || err;
    end
    if (!fin) begin
      errors++;
      $display("FAIL session_end: no done/err within 20 cycles for n=%0d", n);
    end
    check("done", 64'(done), 64'(exp_done));
    check("err", 64'(err), 64'(exp_err));
    check("busy_end", 64'(busy), 64'd0);
    check("word_count", 64'(word_count), 64'(exp_wc));
    check("write_count", 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check($sformatf("write[%0d]", i), obs_q[i], exp_q[i]);
    end
    if (exp_q.size() > 0) begin
      check("addr_hold", {im_addr, im_wdata}, exp_q[exp_q.size()-1]);
    end
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'd0;

    vecs[0] = '{1,    32'hDEADBEEF, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1};
    vecs[1] = '{3,    32'h11111111, 32'h22222222, 32'h33333333, 1'b1, 1'b0, 1'b1, 1'b0, 3};
    vecs[2] = '{0,    32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 0};
    vecs[3] = '{4097, 32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 0};
    vecs[4] = '{1,    32'hCAFEF00D, 32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 1};
    vecs[5] = '{3,    32'h01020304, 32'hA0B0C0D0, 32'h89ABCDEF, 1'b0, 1'b1, 1'b1, 1'b0, 3};

    repeat (3) tick();
    check("rst_ready", 64'(in_ready), 64'd0);
    check("rst_we", 64'(im_we), 64'd0);
    check("rst_addr", 64'(im_addr), 64'(BASE));
    check("rst_wdata", 64'(im_wdata), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_wc", 64'(word_count), 64'd0);
    reset = 1'b1;
    repeat (2) tick();
    check("idle_ready", 64'(in_ready), 64'd0);

    // Table-driven sessions
    for (int v = 0; v < 6; v++) begin
      data_q = '{vecs[v].w0, vecs[v].w1, vecs[v].w2};
      run_session(vecs[v].n, vecs[v].gaps, vecs[v].start_mid,
                  vecs[v].exp_done, vecs[v].exp_err, vecs[v].exp_wc);
    end

    // Randomized sessions against the model
    for (int k = 0; k < 6; k++) begin
      n = (k == 2) ? int'($urandom_range(DEPTH + 1, 65535)) : int'($urandom_range(1, 12));
      data_q.delete();
      for (int i = 0; i < 12; i++) data_q.push_back($urandom);
      run_session(n, 1'b1, (k == 4) && (n > 1), n <= DEPTH, n > DEPTH, (n <= DEPTH) ? n : 0);
    end

    // Full-capacity load: last word lands at 0x6FFC
    data_q.delete();
    for (int i = 0; i < DEPTH; i++) data_q.push_back($urandom);
    run_session(DEPTH, 1'b0, 1'b0, 1'b1, 1'b0, DEPTH);
    check("last_addr", 64'(im_addr), 64'h6FFC);

    // Reset in the middle of the second word of a two-word load
    data_q = '{32'hAAAA5555, 32'h12345678};
    obs_q.delete();
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    for (int b = 0; b < 6; b++) begin
      send_byte(data_q[b/4][31-8*(b%4) -: 8], 1'b0);
    end
    reset = 1'b0;
    #1;
    check("mid_rst_ready", 64'(in_ready), 64'd0);
    check("mid_rst_we", 64'(im_we), 64'd0);
    check("mid_rst_addr", 64'(im_addr), 64'(BASE));
    check("mid_rst_wdata", 64'(im_wdata), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_wc", 64'(word_count), 64'd0);
    in_valid = 1'b1;
    in_data  = 8'h5A;
    repeat (4) tick();
    reset = 1'b1;
    repeat (8) tick();
    in_valid = 1'b0;
    check("mid_rst_idle_busy", 64'(busy), 64'd0);
    check("mid_rst_writes", 64'(obs_q.size()), 64'd1);
    if (obs_q.size() > 0) check("mid_rst_word0", obs_q[0], {BASE, 32'hAAAA5555});

    // Loader is usable again after the aborted session
    data_q = '{32'h0BADC0DE};
    run_session(1, 1'b0, 1'b0, 1'b1, 1'b0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
